// File: rtl/shift_seq_unit.sv
// -----------------------------------------------------------------------------
// shift_seq_unit
//   Multi-cycle shifter that applies one single-bit step per clock.
//   Supported operations: pass, ROR, ASR and RRC (rotate right through carry)
//   by a variable amount. The amount is not reduced modulo WIDTH.
//
// Handshake (start/busy/done):
//   A request is accepted on a rising edge where start=1 and busy=0, which
//   covers both IDLE and DONE, so back-to-back requests are possible.
//   While busy=1, start is ignored and the operands are not re-sampled.
//   done is a one-cycle pulse, with busy=0, in the cycle where Y/C_out hold
//   the new result. Y/C_out change only on entry to DONE and hold their
//   value until the next DONE.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   start      request, accepted only when busy==0
//   op         00 pass, 01 ROR, 10 ASR, 11 RRC
//   amount     number of single-bit steps (0 .. 2**AMT_W-1)
//   A          operand
//   C_in       carry in
//   busy       1 while an operation is in progress (SHIFT state)
//   done       one-cycle pulse when Y/C_out are valid
//   Y          registered result
//   C_out      registered carry out
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module shift_seq_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] A,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             C_out,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ROR  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b10;
  localparam logic [1:0] OP_RRC  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_next;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] count_q;
  logic [WIDTH-1:0] y_q;
  logic             c_out_q;

  logic             accept;
  logic             no_shift_req;
  logic             last_step;
  logic [WIDTH-1:0] step_r;
  logic             step_c;

  // A request can be taken whenever the unit is not busy shifting.
  assign accept       = start && (state_q != S_SHIFT);
  // Pass and zero-amount requests complete without any shift steps.
  assign no_shift_req = (op == OP_PASS) || (amount == '0);
  assign last_step    = (count_q == AMT_W'(1));

  // One single-bit step of the captured operation.
  always_comb begin
    step_r = r_q;
    step_c = c_q;
    unique case (op_q)
      OP_ROR: step_r = {r_q[0], r_q[WIDTH-1:1]};
      OP_ASR: step_r = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      OP_RRC: begin
        // WIDTH+1-bit rotate: the carry enters at the top, bit 0 leaves.
        step_r = {c_q, r_q[WIDTH-1:1]};
        step_c = r_q[0];
      end
      default: begin
        step_r = r_q;
        step_c = c_q;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_next = no_shift_req ? S_DONE : S_SHIFT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (last_step) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= 1'b0;
      op_q    <= OP_PASS;
      count_q <= '0;
      y_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_next;
      if (accept) begin
        r_q     <= A;
        c_q     <= C_in;
        op_q    <= op;
        count_q <= amount;
        if (no_shift_req) begin
          // Result is the operand itself; visible in the very next cycle.
          y_q     <= A;
          c_out_q <= C_in;
        end
      end else if (state_q == S_SHIFT) begin
        r_q     <= step_r;
        c_q     <= step_c;
        count_q <= count_q - AMT_W'(1);
        if (last_step) begin
          // Publish the final step directly so Y is valid on entry to DONE.
          y_q     <= step_r;
          c_out_q <= step_c;
        end
      end
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign Y         = y_q;
  assign C_out     = c_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_unit
//   Directed bench for shift_seq_unit (WIDTH=16, AMT_W=4) with hand-computed
//   expected results, latency and handshake checks, and a summary line.
// -----------------------------------------------------------------------------
module tb_shift_seq_unit;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ROR  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b10;
  localparam logic [1:0] OP_RRC  = 2'b11;

  localparam int WAIT_BUDGET = 40;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] a;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             c_out;
  logic [1:0]       state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_seq_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .amount    (amount),
    .A         (a),
    .C_in      (c_in),
    .busy      (busy),
    .done      (done),
    .Y         (y),
    .C_out     (c_out),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int                 checks   = 0;
  int                 failures = 0;
  logic [WIDTH:0]     exp_q[$];      // {C_out, Y}
  logic [WIDTH-1:0]   last_y   = '0;
  logic               last_c   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present a request at a negedge; it is accepted at the following posedge.
  task automatic drive_req(input logic [1:0] o, input logic [AMT_W-1:0] amt,
                           input logic [WIDTH-1:0] av, input logic ci);
    start  = 1'b1;
    op     = o;
    amount = amt;
    a      = av;
    c_in   = ci;
  endtask

  task automatic clear_req();
    start  = 1'b0;
    op     = OP_PASS;
    amount = '0;
    a      = '0;
    c_in   = 1'b0;
  endtask

  // After the accepting edge, wait for done on negedges; report latency.
  task automatic wait_done(input string tag, input int exp_lat, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(negedge clk);
      if (i == 0 && exp_lat != 0) begin
        check({tag, "_busy_first"}, 32'(busy), 32'd1);
        check({tag, "_y_hold_shift"}, 32'({last_c, last_y}), 32'({c_out, y}));
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  // Check result against the scoreboard head at the done cycle.
  task automatic check_result(input string tag);
    logic [WIDTH:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_y"}, 32'(y), 32'(e[WIDTH-1:0]));
      check({tag, "_c_out"}, 32'(c_out), 32'(e[WIDTH]));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      last_y = e[WIDTH-1:0];
      last_c = e[WIDTH];
    end
  endtask

  // Full single operation: request, latency, result, pulse width, hold.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [AMT_W-1:0] amt,
                        input logic [WIDTH-1:0] av, input logic ci,
                        input logic [WIDTH-1:0] ey, input logic ec, input int exp_lat);
    int lat;
    @(negedge clk);
    drive_req(o, amt, av, ci);
    exp_q.push_back({ec, ey});
    @(posedge clk);
    #1 clear_req();
    wait_done(tag, exp_lat, lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_y_hold_idle"}, 32'(y), 32'(ey));
    check({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int lat;
  int done_count;

  initial begin
    clear_req();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ASR with sign extension; carry passes through unchanged.
    run_op("asr_8001_4", OP_ASR, 4'd4, 16'h8001, 1'b1, 16'hF800, 1'b1, 4);
    run_op("asr_7fff_15", OP_ASR, 4'd15, 16'h7FFF, 1'b0, 16'h0000, 1'b0, 15);
    run_op("asr_8000_15", OP_ASR, 4'd15, 16'h8000, 1'b0, 16'hFFFF, 1'b0, 15);
    // ROR.
    run_op("ror_0001_1", OP_ROR, 4'd1, 16'h0001, 1'b0, 16'h8000, 1'b0, 1);
    run_op("ror_1234_15", OP_ROR, 4'd15, 16'h1234, 1'b1, 16'h2468, 1'b1, 15);
    // RRC through carry.
    run_op("rrc_0001_1", OP_RRC, 4'd1, 16'h0001, 1'b0, 16'h0000, 1'b1, 1);
    run_op("rrc_0001_2", OP_RRC, 4'd2, 16'h0001, 1'b0, 16'h8000, 1'b0, 2);
    run_op("rrc_8000_3", OP_RRC, 4'd3, 16'h8000, 1'b1, 16'h3000, 1'b0, 3);
    // Pass and zero amount complete the cycle after acceptance.
    run_op("amt0_beef", OP_ROR, 4'd0, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 0);
    run_op("pass_beef", OP_PASS, 4'd9, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 0);

    // start during busy is ignored; back-to-back start in DONE is accepted.
    @(negedge clk);
    drive_req(OP_ROR, 4'd8, 16'h0003, 1'b0);
    exp_q.push_back({1'b0, 16'h0300});
    @(posedge clk);
    #1 clear_req();
    repeat (2) @(negedge clk);
    drive_req(OP_RRC, 4'd1, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1 clear_req();
    // Two negedges already consumed of the 8-cycle shift window.
    lat = 2;
    done_count = 0;
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(negedge clk);
      if (done) begin
        done_count = 1;
        break;
      end
      lat++;
    end
    check("ignore_done_seen", 32'(done_count), 32'd1);
    check("ignore_latency", 32'(lat), 32'd8);
    check_result("ignore_busy");
    drive_req(OP_PASS, 4'd0, 16'h1357, 1'b0);
    exp_q.push_back({1'b0, 16'h1357});
    @(posedge clk);
    #1 clear_req();
    @(negedge clk);
    check("b2b_done", 32'(done), 32'd1);
    check_result("b2b");
    @(negedge clk);
    check("b2b_done_pulse", 32'(done), 32'd0);

    // Back-to-back into a shifting op.
    @(negedge clk);
    drive_req(OP_PASS, 4'd0, 16'hA5A5, 1'b1);
    exp_q.push_back({1'b1, 16'hA5A5});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b2_first_done", 32'(done), 32'd1);
    check_result("b2b2_first");
    drive_req(OP_ASR, 4'd2, 16'hA5A5, 1'b0);
    exp_q.push_back({1'b0, 16'hE969});
    @(posedge clk);
    #1 clear_req();
    wait_done("b2b2_second", 2, lat);
    check("b2b2_second_latency", 32'(lat), 32'd2);
    check_result("b2b2_second");

    // Asynchronous reset mid-SHIFT aborts with no done pulse.
    @(negedge clk);
    drive_req(OP_ASR, 4'd10, 16'h8421, 1'b1);
    @(posedge clk);
    #1 clear_req();
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_c_out", 32'(c_out), 32'd0);
    last_y = '0;
    last_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    done_count = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) done_count++;
    end
    check("post_rst_no_done", 32'(done_count), 32'd0);
    run_op("post_rst_ror", OP_ROR, 4'd4, 16'h00F1, 1'b0, 16'h100F, 1'b0, 4);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
